dmem_mmio_responder: RTL and testbench

Memory-mapped I/O responder on the RISCV_TOP data-memory port, sitting in parallel with the D-memory SP_SRAM. It answers core loads/stores in a 16-byte window with a byte-output FIFO (console), a free-running cycle counter, and a sticky halt register. Its drained bytes and halt code give the bench test-pass/fail and console output without probing core internals.

---
 rtl/dmem_mmio_responder_if.sv | 21 ++
 rtl/dmem_mmio_responder.sv | 134 +++++++++++++
 tb/tb_dmem_mmio_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_mmio_responder_if.sv
// Data-memory port bundle between the core (master) and the MMIO responder (slave).
// The registered read path (DOUT, HIT_Q) lets the bench mux responder data over SRAM data.
interface dmem_mmio_responder_if;
    logic        D_MEM_CSN;
    logic        D_MEM_WEN;
    logic [3:0]  D_MEM_BE;
    logic [31:0] D_MEM_ADDR;
    logic [31:0] D_MEM_DI;
    logic [31:0] D_MEM_DOUT;
    logic        HIT_Q;

    modport master (
        output D_MEM_CSN, D_MEM_WEN, D_MEM_BE, D_MEM_ADDR, D_MEM_DI,
        input  D_MEM_DOUT, HIT_Q
    );

    modport slave (
        input  D_MEM_CSN, D_MEM_WEN, D_MEM_BE, D_MEM_ADDR, D_MEM_DI,
        output D_MEM_DOUT, HIT_Q
    );
endinterface

// File: rtl/dmem_mmio_responder.sv
// MMIO responder on the D-memory port: 16-byte window with a console TX FIFO,
// status register, free-running cycle counter and a sticky halt register.
module dmem_mmio_responder #(
    parameter logic [11:0] BASE_ADDR    = 12'hFF0,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    dmem_mmio_responder_if.slave   bus,
    output logic                   TX_VALID,
    output logic [7:0]             TX_BYTE,
    output logic                   HALT,
    output logic [31:0]            HALT_CODE
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

    localparam logic [1:0] SEL_TX    = 2'd0;
    localparam logic [1:0] SEL_STAT  = 2'd1;
    localparam logic [1:0] SEL_CYCLE = 2'd2;
    localparam logic [1:0] SEL_HALT  = 2'd3;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [1:0]  sel;
        logic [3:0]  be;
        logic [31:0] di;
    } req_t;

    req_t        req;
    logic        hit;
    logic        push_req;
    logic        push_ok;
    logic        pop;
    logic        ovf_set;
    logic [31:0] status;
    logic [31:0] rdata;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic [DW-1:0] dcnt;
    logic          ovf;
    logic [31:0]   cycle;
    logic [31:0]   dout;
    logic          hit_q;

    // Only ADDR[11:2] take part in decode; the rest is deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.D_MEM_ADDR[31:12], bus.D_MEM_ADDR[1:0]};

    always_comb begin
        hit     = !bus.D_MEM_CSN && (bus.D_MEM_ADDR[11:4] == BASE_ADDR[11:4]);
        req.rd  = hit && bus.D_MEM_WEN;
        req.wr  = hit && !bus.D_MEM_WEN;
        req.sel = bus.D_MEM_ADDR[3:2];
        req.be  = bus.D_MEM_BE;
        req.di  = bus.D_MEM_DI;
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    always_comb begin
        pop      = (count != '0) && (dcnt == DLAST);
        push_req = req.wr && (req.sel == SEL_TX) && req.be[0];
        push_ok  = push_req && ((count < DEPTH) || pop);
        ovf_set  = push_req && !push_ok;
        status   = {16'b0, 7'b0, ovf, 8'(count)};
        rdata    = 32'b0;
        case (req.sel)
            SEL_STAT:  rdata = status;
            SEL_CYCLE: rdata = cycle;
            SEL_HALT:  rdata = HALT_CODE;
            default:   rdata = 32'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wptr] <= req.di[7:0];
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            dcnt     <= '0;
            ovf      <= 1'b0;
            TX_VALID <= 1'b0;
            TX_BYTE  <= 8'h00;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (count == '0 || dcnt == DLAST) dcnt <= '0;
            else                              dcnt <= dcnt + 1'b1;
            if (ovf_set) ovf <= 1'b1;
            TX_VALID <= pop;
            if (pop) TX_BYTE <= mem[rptr];
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cycle     <= 32'b0;
            HALT      <= 1'b0;
            HALT_CODE <= 32'b0;
            dout      <= 32'b0;
            hit_q     <= 1'b0;
        end else begin
            if (req.wr && req.sel == SEL_CYCLE && req.be == 4'b1111) cycle <= req.di;
            else                                                     cycle <= cycle + 32'd1;
            if (req.wr && req.sel == SEL_HALT && req.be != 4'b0000 && !HALT) begin
                HALT      <= 1'b1;
                HALT_CODE <= req.di;
            end
            if (req.rd) dout <= rdata;
            hit_q <= hit;
        end
    end

    assign bus.D_MEM_DOUT = dout;
    assign bus.HIT_Q      = hit_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: register table, console drain timing,
// FIFO overflow on a slow-drain instance, and reset in the middle of a drain.
module tb_dmem_mmio_responder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_mmio_responder_if bus ();
    dmem_mmio_responder_if bus2 ();

    logic        tx_valid1, tx_valid2, halt1, halt2;
    logic [7:0]  tx_byte1, tx_byte2;
    logic [31:0] halt_code1, halt_code2;

    dmem_mmio_responder dut (
        .CLK(clk), .RSTn(rst_n), .bus(bus),
        .TX_VALID(tx_valid1), .TX_BYTE(tx_byte1), .HALT(halt1), .HALT_CODE(halt_code1)
    );

    dmem_mmio_responder #(.DRAIN_CYCLES(100)) dut2 (
        .CLK(clk), .RSTn(rst_n), .bus(bus2),
        .TX_VALID(tx_valid2), .TX_BYTE(tx_byte2), .HALT(halt2), .HALT_CODE(halt_code2)
    );

    typedef struct {
        int         c;
        logic [7:0] b;
    } tx_ev_t;

    typedef struct {
        logic        csn;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] di;
        logic [31:0] dout;
        logic        hitq;
    } vec_t;

    int     cyc = 0;
    int     ntests = 0;
    int     nfail = 0;
    tx_ev_t txq1[$];
    tx_ev_t txq2[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        tx_ev_t e;
        if (tx_valid1) begin
            e.c = cyc; e.b = tx_byte1; txq1.push_back(e);
        end
        if (tx_valid2) begin
            e.c = cyc; e.b = tx_byte2; txq2.push_back(e);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One bus access on instance d, sampled by the next rising edge; returns at the falling edge.
    task automatic op(input int d, input logic csn, input logic wen, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] di);
        if (d == 0) begin
            bus.D_MEM_CSN = csn; bus.D_MEM_WEN = wen; bus.D_MEM_BE = be;
            bus.D_MEM_ADDR = addr; bus.D_MEM_DI = di;
        end else begin
            bus2.D_MEM_CSN = csn; bus2.D_MEM_WEN = wen; bus2.D_MEM_BE = be;
            bus2.D_MEM_ADDR = addr; bus2.D_MEM_DI = di;
        end
        @(negedge clk);
        bus.D_MEM_CSN  = 1'b1;
        bus2.D_MEM_CSN = 1'b1;
    endtask

    task automatic wr(input int d, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] di);
        op(d, 1'b0, 1'b0, be, addr, di);
    endtask

    task automatic rd(input int d, input logic [31:0] addr);
        op(d, 1'b0, 1'b1, 4'hF, addr, 32'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) op(0, 1'b1, 1'b1, 4'h0, 32'h0, 32'h0);
    endtask

    vec_t vt[18];
    int   e0, p0, r0, base;

    initial begin
        //          csn   wen   be     addr          di             dout           hitq
        vt[0]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0FF8, 32'h0,         32'h0,         1'b1};
        vt[1]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0FFC, 32'h0,         32'h0,         1'b1};
        vt[2]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0FF4, 32'h0,         32'h0,         1'b1};
        vt[3]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0100, 32'h0,         32'h0,         1'b0};
        vt[4]  = '{1'b0, 1'b0, 4'hF, 32'h0000_0FF8, 32'hFFFF_FFFE, 32'h0,         1'b1};
        vt[5]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0FF8, 32'h0,         32'hFFFF_FFFE, 1'b1};
        vt[6]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0FF8, 32'h0,         32'hFFFF_FFFF, 1'b1};
        vt[7]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0FF8, 32'h0,         32'h0,         1'b1};
        vt[8]  = '{1'b0, 1'b0, 4'h3, 32'h0000_0FF8, 32'h0,         32'h0,         1'b1};
        vt[9]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0FF8, 32'h0,         32'h2,         1'b1};
        vt[10] = '{1'b0, 1'b1, 4'hF, 32'h0000_0100, 32'h0,         32'h2,         1'b0};
        vt[11] = '{1'b0, 1'b0, 4'h2, 32'h0000_0FF0, 32'h55,        32'h2,         1'b1};
        vt[12] = '{1'b0, 1'b1, 4'hF, 32'h0000_0FF4, 32'h0,         32'h0,         1'b1};
        vt[13] = '{1'b0, 1'b0, 4'h1, 32'h0000_0FFC, 32'h1,         32'h0,         1'b1};
        vt[14] = '{1'b0, 1'b0, 4'hF, 32'h0000_0FFC, 32'hDEAD,      32'h0,         1'b1};
        vt[15] = '{1'b0, 1'b1, 4'hF, 32'h0000_0FFD, 32'h0,         32'h1,         1'b1};
        vt[16] = '{1'b0, 1'b1, 4'hF, 32'h0000_0FF0, 32'h0,         32'h0,         1'b1};
        vt[17] = '{1'b1, 1'b1, 4'hF, 32'h0000_0FFC, 32'h0,         32'h0,         1'b0};

        rst_n = 1'b0;
        bus.D_MEM_CSN = 1'b1;  bus.D_MEM_WEN = 1'b1;  bus.D_MEM_BE = 4'h0;
        bus.D_MEM_ADDR = 32'h0; bus.D_MEM_DI = 32'h0;
        bus2.D_MEM_CSN = 1'b1; bus2.D_MEM_WEN = 1'b1; bus2.D_MEM_BE = 4'h0;
        bus2.D_MEM_ADDR = 32'h0; bus2.D_MEM_DI = 32'h0;
        repeat (2) @(negedge clk);

        chk("rst_dout",      bus.D_MEM_DOUT, 32'h0);
        chk("rst_hitq",      {31'b0, bus.HIT_Q}, 32'h0);
        chk("rst_tx_valid",  {31'b0, tx_valid1}, 32'h0);
        chk("rst_tx_byte",   {24'b0, tx_byte1}, 32'h0);
        chk("rst_halt",      {31'b0, halt1}, 32'h0);
        chk("rst_halt_code", halt_code1, 32'h0);
        rst_n = 1'b1;

        // Register table; row 0 reads CYCLE at the first edge after release.
        for (int i = 0; i < 18; i++) begin
            op(0, vt[i].csn, vt[i].wen, vt[i].be, vt[i].addr, vt[i].di);
            chk($sformatf("vec%0d_dout", i), bus.D_MEM_DOUT, vt[i].dout);
            chk($sformatf("vec%0d_hitq", i), {31'b0, bus.HIT_Q}, {31'b0, vt[i].hitq});
        end
        chk("halt_set",      {31'b0, halt1}, 32'h1);
        chk("halt_code_kept", halt_code1, 32'h1);
        chk("no_spurious_tx", txq1.size(), 32'd0);

        // Console: two back-to-back pushes drain 4 cycles apart.
        wr(0, 32'hFF0, 4'h1, 32'h48);
        e0 = cyc;
        wr(0, 32'hFF0, 4'h1, 32'h69);
        rd(0, 32'hFF4); chk("stat_2", bus.D_MEM_DOUT, 32'h2);
        idle(2);
        rd(0, 32'hFF4); chk("stat_1", bus.D_MEM_DOUT, 32'h1);
        idle(3);
        rd(0, 32'hFF4); chk("stat_0", bus.D_MEM_DOUT, 32'h0);
        idle(3);
        chk("tx_count", txq1.size(), 32'd2);
        if (txq1.size() >= 2) begin
            chk("tx0_time", txq1[0].c, e0 + 4);
            chk("tx0_byte", {24'b0, txq1[0].b}, 32'h48);
            chk("tx1_time", txq1[1].c, e0 + 8);
            chk("tx1_byte", {24'b0, txq1[1].b}, 32'h69);
        end
        chk("tx_byte_hold", {24'b0, tx_byte1}, 32'h69);
        chk("tx_valid_low", {31'b0, tx_valid1}, 32'h0);

        // Slow drain: overflow, then a push on the pop edge while full.
        for (int i = 0; i < 10; i++) begin
            wr(1, 32'hFF0, 4'h1, 32'hA0 + i);
            if (i == 0) p0 = cyc;
        end
        rd(1, 32'hFF4); chk("ovf_stat", bus2.D_MEM_DOUT, 32'h108);
        while (cyc < p0 + 99) idle(1);
        wr(1, 32'hFF0, 4'h1, 32'hBB);
        rd(1, 32'hFF4); chk("full_pop_push_stat", bus2.D_MEM_DOUT, 32'h108);
        while (cyc < p0 + 905) idle(1);
        chk("slow_tx_count", txq2.size(), 32'd9);
        if (txq2.size() >= 9) begin
            for (int k = 0; k < 9; k++) begin
                chk($sformatf("slow_tx%0d_time", k), txq2[k].c, p0 + 100 * (k + 1));
                chk($sformatf("slow_tx%0d_byte", k), {24'b0, txq2[k].b},
                    (k < 8) ? 32'hA0 + k : 32'hBB);
            end
        end
        rd(1, 32'hFF4); chk("ovf_sticky", bus2.D_MEM_DOUT, 32'h100);

        // Reset with bytes still queued.
        base = txq1.size();
        wr(0, 32'hFF0, 4'h1, 32'h11);
        r0 = cyc;
        wr(0, 32'hFF0, 4'h1, 32'h22);
        wr(0, 32'hFF0, 4'h1, 32'h33);
        idle(3);
        chk("pre_rst_pops", txq1.size() - base, 32'd1);
        chk("pre_rst_cyc", cyc, r0 + 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_byte",   {24'b0, tx_byte1}, 32'h0);
        chk("mid_rst_tx_valid",  {31'b0, tx_valid1}, 32'h0);
        chk("mid_rst_halt",      {31'b0, halt1}, 32'h0);
        chk("mid_rst_halt_code", halt_code1, 32'h0);
        chk("mid_rst_dout2",     bus2.D_MEM_DOUT, 32'h0);
        chk("mid_rst_hitq",      {31'b0, bus.HIT_Q}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        chk("post_rst_no_tx", txq1.size() - base, 32'd1);
        rd(0, 32'hFF4); chk("post_rst_stat", bus.D_MEM_DOUT, 32'h0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
